// File: rtl/deser_stream.sv
// Serial-to-parallel packer: gathers BEATS beats of IN_W bits into one word held in a
// registered output slot under valid/ready, with in_last flushing a partial word early.
module deser_stream #(
    parameter int IN_W      = 1,
    parameter int BEATS     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_W-1:0]              in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IN_W*BEATS-1:0]        out_data,
    output logic [$clog2(BEATS+1)-1:0]   out_beats,
    output logic                         out_last
);

    localparam int CW = $clog2(BEATS + 1);
    localparam int OW = IN_W * BEATS;

    logic [CW-1:0] cnt_r;
    logic [OW-1:0] acc_r;
    logic          out_valid_r;
    logic [OW-1:0] out_data_r;
    logic [CW-1:0] out_beats_r;
    logic          out_last_r;

    logic          in_ready_s;
    logic          xfer_s;
    logic          close_s;
    int            slot_s;
    logic [OW-1:0] acc_next_s;

    // Handshake decode and accumulator with the current beat merged into its slice
    always_comb begin
        in_ready_s = 1'b0;
        xfer_s     = 1'b0;
        close_s    = 1'b0;
        slot_s     = 0;
        acc_next_s = acc_r;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = !out_valid_r || out_ready;
        end
        xfer_s  = in_valid && in_ready_s;
        close_s = xfer_s && ((cnt_r == CW'(BEATS - 1)) || in_last);
        if (LSB_FIRST) begin
            slot_s = int'(cnt_r);
        end else begin
            slot_s = BEATS - 1 - int'(cnt_r);
        end
        for (int i = 0; i < BEATS; i++) begin
            if (i == slot_s) begin
                acc_next_s[i*IN_W +: IN_W] = in_data;
            end else begin
                acc_next_s[i*IN_W +: IN_W] = acc_r[i*IN_W +: IN_W];
            end
        end
    end

    // Accumulator, beat counter and output holding slot
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= {CW{1'b0}};
            acc_r       <= {OW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {OW{1'b0}};
            out_beats_r <= {CW{1'b0}};
            out_last_r  <= 1'b0;
        end else if (close_s) begin
            // A closing beat may overwrite a word being consumed this same cycle
            out_valid_r <= 1'b1;
            out_data_r  <= acc_next_s;
            out_beats_r <= cnt_r + CW'(1);
            out_last_r  <= in_last;
            cnt_r       <= {CW{1'b0}};
            acc_r       <= {OW{1'b0}};
        end else begin
            if (xfer_s) begin
                acc_r <= acc_next_s;
                cnt_r <= cnt_r + CW'(1);
            end else begin
                acc_r <= acc_r;
                cnt_r <= cnt_r;
            end
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_beats = out_beats_r;
    assign out_last  = out_last_r;

endmodule
